id_ex_ctrl_stage: RTL
=====================

// Module: id_ex_ctrl_stage
// PURPOSE
//   ID/EX control pipeline stage of the 5-stage RV32I core. Latches the 9 decoded control bits and rd.
//   Detects load-use and ecall-x17 RAW hazards and stalls PC/IF-ID while inserting bubbles.
//   Sequences the halt on "ecall with x17==10": drains EX/MEM/WB, then asserts is_halted.
//   Sits between the opcode decoder (upstream) and the EX stage (downstream).
// PARAMETERS
//   DRAIN_CYCLES  3   cycles spent in DRAIN after halt-ecall is accepted (EX+MEM+WB); legal range 1..7
//   ECALL_REG     17  architectural register read by ecall (a7)
// PORTS
//   clk            in   1  rising-edge clock
//   reset          in   1  synchronous, active-high
//   id_ctrl        in   9  {mem_read,mem_to_reg,mem_write,alu_src,write_enable,pc_to_reg,alu_op[1:0],is_ecall}
//   id_rs1/id_rs2  in   5  source registers of instruction in ID
//   id_use_rs1/2   in   1  instruction in ID actually reads rs1/rs2
//   id_rd          in   5  destination register of instruction in ID
//   halt_cond      in   1  x17 value read in ID equals 10 (combinational, from register-file read)
//   flush          in   1  zero ID/EX this cycle (taken branch/jump resolved later)
//   mem_rd         in   5  rd held in EX/MEM (used only when DATA_FWD_EN is undefined)
//   mem_we         in   1  write_enable held in EX/MEM (used only when DATA_FWD_EN is undefined)
//   ex_ctrl        out  9  registered control bundle to EX
//   ex_rd          out  5  registered rd to EX
//   pc_write       out  1  0 = hold PC
//   if_id_write    out  1  0 = hold IF/ID
//   is_halted      out  1  registered; high once drain is complete, sticky until reset
// BEHAVIOUR
//   Reset (sync): ex_ctrl=0, ex_rd=0, state=RUN, drain_cnt=0, is_halted=0; pc_write/if_id_write=1 in RUN.
//   hazard (comb., RUN only): hz = ex_ctrl.mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))
//     | id_ctrl.is_ecall & ex_ctrl.write_enable & ex_rd==ECALL_REG.
//   hz=1 -> pc_write=0, if_id_write=0, ID/EX loads bubble (ex_ctrl=0, ex_rd=0); instruction is retried next cycle.
//   ID/EX update priority: reset > flush > (state!=RUN) bubble > hz bubble > load {id_ctrl,id_rd}.
//   flush overrides the bubble but does not clear the stall; flush while ecall is in ID cancels halt acceptance.
//   FSM states:
//     RUN    : if id_ctrl.is_ecall & halt_cond & !hz & !flush -> DRAIN, drain_cnt<=DRAIN_CYCLES.
//              The ecall itself enters ID/EX (is_ecall=1, write_enable=0).
//     DRAIN  : pc_write=0, if_id_write=0, bubbles into ID/EX; drain_cnt decrements by 1 each cycle;
//              drain_cnt==1 -> HALTED.
//     HALTED : pc_write=0, if_id_write=0, ex_ctrl=0, is_halted=1; exits only on reset.
//   Timing: ecall accepted at edge T -> DRAIN for cycles T+1..T+DRAIN_CYCLES -> is_halted high from T+DRAIN_CYCLES+1.
//   Ecall without halt_cond: passes through as a normal instruction; no state change.
//   Reset mid-DRAIN/HALTED: returns to RUN next edge, is_halted=0.
//   ex_rd==0 never raises a load-use hazard (x0 is hardwired).
// CONFIGURATION
//   DATA_FWD_EN defined  : EX/MEM->EX and MEM/WB->EX forwarding exists; only the hazards listed above stall.
//   DATA_FWD_EN undefined: additionally stall on any RAW against a writer in EX (ex_ctrl.write_enable & ex_rd!=0)
//                          or MEM (mem_we & mem_rd!=0) for used rs1/rs2 and for the ecall x17 read;
//                          the register file writes first half / reads second half, so WB is not checked.
// STRUCTURE
//   Shared header pipeline_defs.v: CTRL_W=9, bit indices of each control field, ALU_OP encodings,
//   FSM state encodings (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2), ECALL_HALT_VAL=10.
//   Sub-module hazard_detect (combinational): produces hz from IDs, ex/mem rd and write enables; macro-aware.
//   Top holds the ID/EX registers, FSM and drain counter.
// TESTING
//   1. ex: lw x5 (mem_read=1, ex_rd=5); id: add reading rs1=5 -> pc_write=0, if_id_write=0, next ex_ctrl=0; following cycle add loads.
//   2. ex: lw x0; id: rs1=0 -> no stall; ex: lw x5 with id_use_rs2=0 & id_rs2=5 -> no stall.
//   3. id: ecall, halt_cond=1, no hazard at edge T -> DRAIN at T+1..T+3, is_halted=1 at T+4 and held 20 cycles; reset -> is_halted=0, state RUN.
//   4. ex: addi x17 (write_enable=1, ex_rd=17); id: ecall -> 1-cycle stall, then halt accepted.
//   5. flush=1 with a stall hazard present -> ex_ctrl=0 and pc_write=0; flush with halt-ecall in ID -> stays RUN.
//   6. DATA_FWD_EN undefined: mem_we=1, mem_rd=3; id: add rs2=3 -> stall; with DATA_FWD_EN defined -> no stall.

Source files
------------

// File: rtl/id_ex_ctrl_stage_pkg.sv
// Shared definitions for the ID/EX control stage: control-bundle layout, ALU op
// encodings, FSM state encodings and the halt value checked by ecall.
package id_ex_ctrl_stage_pkg;

    localparam int unsigned CTRL_W = 9;

    // Bit positions inside the 9-bit control bundle
    localparam int unsigned CTRL_MEM_READ    = 8;
    localparam int unsigned CTRL_MEM_TO_REG  = 7;
    localparam int unsigned CTRL_MEM_WRITE   = 6;
    localparam int unsigned CTRL_ALU_SRC     = 5;
    localparam int unsigned CTRL_WRITE_EN    = 4;
    localparam int unsigned CTRL_PC_TO_REG   = 3;
    localparam int unsigned CTRL_ALU_OP_HI   = 2;
    localparam int unsigned CTRL_ALU_OP_LO   = 1;
    localparam int unsigned CTRL_IS_ECALL    = 0;

    // ALU op field encodings
    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

    localparam int unsigned ECALL_HALT_VAL = 10;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2
    } state_e;

endpackage

// File: rtl/id_ex_ctrl_stage_hazard_detect.sv
// Combinational RAW hazard detector for the instruction in ID.
// Always flags load-use and ecall-vs-x17 writer in EX. When DATA_FWD_EN is not
// defined there is no forwarding, so any writer in EX or MEM also stalls.
module id_ex_ctrl_stage_hazard_detect #(
    parameter int unsigned ECALL_REG = 17
) (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       id_is_ecall,
    input  logic       ex_mem_read,
    input  logic       ex_we,
    input  logic [4:0] ex_rd,
    input  logic       mem_we,
    input  logic [4:0] mem_rd,
    output logic       hz
);

    localparam logic [4:0] EcallRd = 5'(ECALL_REG);

    logic match_ex;
    logic x17_ex;
    logic ex_rd_nz;

    // Register match terms and final hazard decision
    always_comb begin
        ex_rd_nz = (ex_rd != 5'd0);
        match_ex = (id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd));
        x17_ex   = id_is_ecall & (ex_rd == EcallRd);
        hz = (ex_mem_read & ex_rd_nz & match_ex) | (x17_ex & ex_we);
`ifndef DATA_FWD_EN
        // No bypass network: wait until EX and MEM writers have reached WB
        hz = hz | (ex_we & ex_rd_nz & (match_ex | x17_ex));
        hz = hz | (mem_we & (mem_rd != 5'd0) &
                   ((id_use_rs1 & (id_rs1 == mem_rd)) |
                    (id_use_rs2 & (id_rs2 == mem_rd)) |
                    (id_is_ecall & (mem_rd == EcallRd))));
`endif
    end

`ifdef DATA_FWD_EN
    // MEM-stage writer is covered by forwarding in this build
    logic unused_mem;
    assign unused_mem = ^{mem_we, mem_rd};
`endif

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control pipeline stage: latches decoded control bits and rd, stalls
// PC/IF-ID on RAW hazards by inserting bubbles, and sequences the halt on an
// ecall with x17 == 10 (drain EX/MEM/WB, then raise sticky is_halted).
// Optional build macro: DATA_FWD_EN (forwarding present, fewer stall cases).
module id_ex_ctrl_stage
    import id_ex_ctrl_stage_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned ECALL_REG    = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CTRL_W-1:0]   id_ctrl,
    input  logic [4:0]          id_rs1,
    input  logic [4:0]          id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [4:0]          id_rd,
    input  logic                halt_cond,
    input  logic                flush,
    input  logic [4:0]          mem_rd,
    input  logic                mem_we,
    output logic [CTRL_W-1:0]   ex_ctrl,
    output logic [4:0]          ex_rd,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                is_halted
);

    localparam logic [2:0] DrainInit = 3'(DRAIN_CYCLES);

    state_e              state_q, state_d;
    logic [2:0]          drain_cnt_q, drain_cnt_d;
    logic [CTRL_W-1:0]   ex_ctrl_q, ex_ctrl_d;
    logic [4:0]          ex_rd_q, ex_rd_d;
    logic                halted_q, halted_d;
    logic                hz_raw, hz, in_run, halt_accept;

    id_ex_ctrl_stage_hazard_detect #(
        .ECALL_REG (ECALL_REG)
    ) u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_is_ecall (id_ctrl[CTRL_IS_ECALL]),
        .ex_mem_read (ex_ctrl_q[CTRL_MEM_READ]),
        .ex_we       (ex_ctrl_q[CTRL_WRITE_EN]),
        .ex_rd       (ex_rd_q),
        .mem_we      (mem_we),
        .mem_rd      (mem_rd),
        .hz          (hz_raw)
    );

    // Hazards only matter while fetching; halt is taken only for a clean, unflushed ecall
    always_comb begin
        in_run      = (state_q == StRun);
        hz          = in_run & hz_raw;
        halt_accept = in_run & id_ctrl[CTRL_IS_ECALL] & halt_cond & ~hz & ~flush;
    end

    // FSM next state, drain counter and stall outputs
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        halted_d    = halted_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        unique case (state_q)
            StRun: begin
                if (hz) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                end
                if (halt_accept) begin
                    state_d     = StDrain;
                    drain_cnt_d = DrainInit;
                end
            end
            StDrain: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                drain_cnt_d = drain_cnt_q - 3'd1;
                if (drain_cnt_q == 3'd1) begin
                    state_d  = StHalted;
                    halted_d = 1'b1;
                end
            end
            StHalted: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                halted_d    = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // ID/EX next value: flush, non-RUN and hazard all insert a bubble
    always_comb begin
        ex_ctrl_d = id_ctrl;
        ex_rd_d   = id_rd;
        if (flush || !in_run || hz) begin
            ex_ctrl_d = '0;
            ex_rd_d   = '0;
        end
    end

    // State and ID/EX registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            drain_cnt_q <= 3'd0;
            ex_ctrl_q   <= '0;
            ex_rd_q     <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rd_q     <= ex_rd_d;
            halted_q    <= halted_d;
        end
    end

    assign ex_ctrl   = ex_ctrl_q;
    assign ex_rd     = ex_rd_q;
    assign is_halted = halted_q;

endmodule
